// File: rtl/divider_pkg.sv
// divider_pkg: shared divider encodings, bus widths and negation helper
package divider_pkg;
  localparam int REG_BUS = 32;
  localparam int DOUBLE_REG_BUS = 64;
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP = 1'b0;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;
  function automatic logic [REG_BUS-1:0] neg(input logic [REG_BUS-1:0] v);
    return ~v + 1'b1;
  endfunction
endpackage

// File: rtl/divider.sv
// divider: multi-cycle 32-bit restoring divider for DIV/DIVU (one quotient bit per cycle)
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   signed_div_in 1 = DIV (signed), 0 = DIVU
//   opdata1_in    dividend, latched at start
//   opdata2_in    divisor, latched at start
//   start_in      start level, held high until ready_out is seen
//   annul_in      abort (pipeline flush)
//   result_out    {remainder, quotient}, registered
//   ready_out     result_out valid, registered
//   Optional macro DIV_ZERO_DETECT_EN: zero divisor short-circuits to a zero result.
module divider
  import divider_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signed_div_in,
  input  logic [REG_BUS-1:0]        opdata1_in,
  input  logic [REG_BUS-1:0]        opdata2_in,
  input  logic                      start_in,
  input  logic                      annul_in,
  output logic [DOUBLE_REG_BUS-1:0] result_out,
  output logic                      ready_out
);
  div_state_e state, state_nxt;
  // {partial remainder, dividend}; the shifted-out top bit is always 0, so 64 bits suffice
  logic [63:0] acc;
  logic [31:0] dvs;
  logic [5:0] cnt;
  logic s1, s2, sgn;
  logic [63:0] res;
  logic [32:0] diff;
  logic [63:0] step;
  logic [31:0] fix_q, fix_r;
  logic zero_div, go, abort, last;
`ifdef DIV_ZERO_DETECT_EN
  assign zero_div = opdata2_in == '0;
`else
  assign zero_div = 1'b0;
`endif
  assign go = start_in == DIV_START && !annul_in;
  assign abort = annul_in || start_in == DIV_STOP;
  assign last = cnt == 6'd31;
  // trial subtraction of the divisor from the shifted upper 33 bits
  assign diff = acc[63:31] - {1'b0, dvs};
  assign step = diff[32] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1};
  assign fix_q = sgn && (s1 ^ s2) ? neg(step[31:0]) : step[31:0];
  assign fix_r = sgn && s1 ? neg(step[63:32]) : step[63:32];
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= DIV_FREE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    unique case (state)
      DIV_FREE:    state_nxt = go ? (zero_div ? DIV_BY_ZERO : DIV_ON) : DIV_FREE;
      DIV_BY_ZERO: state_nxt = DIV_END;
      DIV_ON:      state_nxt = abort ? DIV_FREE : (last ? DIV_END : DIV_ON);
      DIV_END:     state_nxt = start_in == DIV_START ? DIV_END : DIV_FREE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      result_out <= '0;
      ready_out <= DIV_RESULT_NOT_READY;
      acc <= '0;
      dvs <= '0;
      cnt <= '0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      sgn <= 1'b0;
      res <= '0;
    end else begin
      unique case (state)
        DIV_FREE: begin
          result_out <= '0;
          ready_out <= DIV_RESULT_NOT_READY;
          if (go) begin
            acc <= {32'd0, signed_div_in && opdata1_in[31] ? neg(opdata1_in) : opdata1_in};
            dvs <= signed_div_in && opdata2_in[31] ? neg(opdata2_in) : opdata2_in;
            s1 <= opdata1_in[31];
            s2 <= opdata2_in[31];
            sgn <= signed_div_in;
            cnt <= '0;
          end
        end
        DIV_BY_ZERO: res <= '0;
        DIV_ON:
          if (abort) begin
            cnt <= '0;
            ready_out <= DIV_RESULT_NOT_READY;
          end else begin
            acc <= step;
            cnt <= cnt + 6'd1;
            if (last) res <= {fix_r, fix_q};
          end
        DIV_END: begin
          result_out <= start_in == DIV_START ? res : '0;
          ready_out <= start_in == DIV_START ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
        end
      endcase
    end
endmodule

// File: tb/tb_divider.sv
// tb_divider: directed self-checking bench for divider
module tb_divider;
  logic clk = 1'b0;
  logic rst;
  logic signed_div_in;
  logic [31:0] opdata1_in, opdata2_in;
  logic start_in, annul_in;
  logic [63:0] result_out;
  logic ready_out;
  int errors = 0;
  int checks = 0;
  divider dut (
    .clk(clk),
    .rst(rst),
    .signed_div_in(signed_div_in),
    .opdata1_in(opdata1_in),
    .opdata2_in(opdata2_in),
    .start_in(start_in),
    .annul_in(annul_in),
    .result_out(result_out),
    .ready_out(ready_out)
  );
  always #5 clk = ~clk;
  task automatic test_reset;
    checks++;
    if (ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", ready_out); end
    checks++;
    if (result_out !== 64'd0) begin errors++; $display("FAIL reset_result got=%h want=0", result_out); end
  endtask
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sd,
                         input logic [63:0] exp, input int exp_lat, input string nm);
    int lat;
    @(negedge clk);
    opdata1_in = a;
    opdata2_in = b;
    signed_div_in = sd;
    start_in = 1'b1;
    lat = -1;
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      if (n == 0) begin
        opdata1_in = ~a;
        opdata2_in = b + 32'd7;
        signed_div_in = ~sd;
      end
      if (ready_out) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat !== exp_lat) begin errors++; $display("FAIL %s_latency got=%0d want=%0d", nm, lat, exp_lat); end
    checks++;
    if (result_out !== exp) begin errors++; $display("FAIL %s_result got=%h want=%h", nm, result_out, exp); end
    repeat (3) @(negedge clk);
    checks++;
    if (ready_out !== 1'b1 || result_out !== exp) begin
      errors++;
      $display("FAIL %s_hold got=%b/%h want=1/%h", nm, ready_out, result_out, exp);
    end
    start_in = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_out !== 1'b0 || result_out !== 64'd0) begin
      errors++;
      $display("FAIL %s_drop got=%b/%h want=0/0", nm, ready_out, result_out);
    end
  endtask
  task automatic test_unsigned;
    run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, "divu_100_7");
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 32'hFFFFFFFF}, 33, "divu_max_1");
  endtask
  task automatic test_signed;
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, "div_m7_2");
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, {32'd1, 32'hFFFFFFFD}, 33, "div_7_m2");
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'd0, 32'h80000000}, 33, "div_ovf");
  endtask
  task automatic test_div_zero;
`ifdef DIV_ZERO_DETECT_EN
    run_div(32'd5, 32'd0, 1'b0, 64'd0, 2, "divu_5_0");
`else
    run_div(32'd5, 32'd0, 1'b0, {32'd5, 32'hFFFFFFFF}, 33, "divu_5_0");
`endif
  endtask
  task automatic test_abort(input int at, input logic use_annul, input string nm);
    logic seen;
    @(negedge clk);
    opdata1_in = 32'd1000;
    opdata2_in = 32'd7;
    signed_div_in = 1'b0;
    start_in = 1'b1;
    repeat (at) @(negedge clk);
    if (use_annul) annul_in = 1'b1;
    else start_in = 1'b0;
    @(negedge clk);
    annul_in = 1'b0;
    start_in = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_out) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL %s_no_ready got=%b want=0", nm, seen); end
    run_div(32'd9, 32'd3, 1'b0, 64'd3, 33, {nm, "_after"});
  endtask
  task automatic test_async_reset;
    logic seen;
    @(negedge clk);
    opdata1_in = 32'd100;
    opdata2_in = 32'd7;
    signed_div_in = 1'b0;
    start_in = 1'b1;
    repeat (15) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ready_out !== 1'b0 || result_out !== 64'd0) begin
      errors++;
      $display("FAIL rst_mid_on got=%b/%h want=0/0", ready_out, result_out);
    end
    start_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_out) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_idle got=%b want=0", seen); end
    start_in = 1'b1;
    for (int n = 0; n < 45 && !ready_out; n++) @(negedge clk);
    checks++;
    if (result_out !== {32'd2, 32'd14}) begin
      errors++;
      $display("FAIL rst_before_end got=%h want=%h", result_out, {32'd2, 32'd14});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ready_out !== 1'b0 || result_out !== 64'd0) begin
      errors++;
      $display("FAIL rst_in_end got=%b/%h want=0/0", ready_out, result_out);
    end
    start_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_div(32'd9, 32'd3, 1'b0, 64'd3, 33, "rst_after");
  endtask
  initial begin
    rst = 1'b0;
    signed_div_in = 1'b0;
    opdata1_in = '0;
    opdata2_in = '0;
    start_in = 1'b0;
    annul_in = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b1;
    test_unsigned;
    test_signed;
    test_div_zero;
    test_abort(10, 1'b1, "annul");
    test_abort(20, 1'b0, "stop");
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/divider.md
# divider

Multi-cycle 32-bit integer divider serving the execute stage for DIV/DIVU. Execute drives operands, signedness and a start level, holds the pipeline stalled while `ready_out` is low, then writes remainder to HI and quotient to LO. The result is produced by radix-2 restoring division, one quotient bit per cycle, under a four-state FSM.

## Interface
- No parameters; widths are fixed by the shared defines (RegBus = 32, DoubleRegBus = 64).
- clk  in  1  — single clock, rising edge.
- rst  in  1  — asynchronous, active-low reset.
- signed_div_in  in  1  — 1 = DIV (signed), 0 = DIVU.
- opdata1_in  in  32  — dividend.
- opdata2_in  in  32  — divisor.
- start_in  in  1  — DivStart/DivStop level from execute; held high until ready is seen.
- annul_in  in  1  — abort request (pipeline flush).
- result_out  out  64  — {remainder[63:32], quotient[31:0]}, registered.
- ready_out  out  1  — DivResultReady when result_out is valid, registered.

## Operation
- States: DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END.
- Reset (rst low, any time): state DIV_FREE, result_out = 0, ready_out = DivResultNotReady, iteration counter = 0. Takes effect immediately and aborts any division in progress.
- DIV_FREE, start_in = 1 and annul_in = 0:
  - If the divisor is 0 (with the zero-detect feature enabled), go to DIV_BY_ZERO.
  - Otherwise latch operands into the working registers. When signed_div_in = 1, latch the absolute value of any negative operand. Record both operand signs, clear the counter and go to DIV_ON.
- DIV_FREE, any other input: stay in DIV_FREE; ready_out = 0; result_out = 0.
- DIV_BY_ZERO: go to DIV_END with result = 0.
- DIV_ON, annul_in = 0 and start_in = 1, each cycle:
  - Shift the 65-bit {partial remainder, dividend} register left by one.
  - Compute the trial difference = upper 33 bits − {1'b0, divisor}.
  - If the difference is non-negative, replace the upper bits with it and set the quotient LSB to 1.
  - Increment the counter.
- DIV_ON, after the 32nd iteration, apply the sign fix in the same cycle's update:
  - Signed division with differing operand signs: negate the quotient (two's complement).
  - Signed division with a negative dividend: negate the remainder.
  - Then go to DIV_END and load result_out with ready_out = 1.
- DIV_ON, annul_in = 1 or start_in = 0: go to DIV_FREE, ready_out = 0, counter cleared. Annul has priority over completion in the same cycle.
- DIV_END:
  - Hold result_out and ready_out = 1 while start_in = 1.
  - When start_in = 0, go to DIV_FREE and clear result_out and ready_out on that edge.
- Overflow case: signed −2^31 / −1 gives quotient 0x80000000 and remainder 0, with no exception.
- Operands changing during DIV_ON are ignored; only the values latched in DIV_FREE count.

## Timing
- Let T be the edge that samples start_in = 1 in DIV_FREE.
- Normal division: ready_out is first high during cycle T+33, i.e. 32 DIV_ON cycles followed by the DIV_END load.
- Divide-by-zero fast path: ready_out is high at T+2.
- Throughput: one divide in flight. A new start is accepted only in DIV_FREE, so back-to-back divides are separated by at least one DIV_FREE cycle.
- ready_out drops one cycle after execute deasserts start_in.

## Configuration
- `DIV_ZERO_DETECT_EN` defined:
  - A zero divisor takes the DIV_BY_ZERO path.
  - Result is 0 and latency is 2 cycles.
- `DIV_ZERO_DETECT_EN` undefined:
  - DIV_BY_ZERO is unreachable and a zero divisor runs the full 32 iterations.
  - Unsigned result: quotient 0xFFFFFFFF, remainder = dividend.
  - Signed result: the sign fix is applied to the same raw values.

## Structure
- Shared defines file holds:
  - DivFree/DivByZero/DivOn/DivEnd 2-bit encodings.
  - DivStart/DivStop and DivResultReady/DivResultNotReady.
  - RegBus/DoubleRegBus.
- No sub-module: the iteration step and sign fix stay inline.

## Test plan
- DIVU 100 / 7 → ready at T+33, result_out = {32'd2, 32'd14}; ready stays high until start drops, then falls one cycle later.
- DIV −7 / 2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). DIV 7 / −2 → quotient −3, remainder 1.
- DIV 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}. DIVU 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- Divide 5 / 0:
  - With DIV_ZERO_DETECT_EN: ready at T+2, result 0.
  - Without it: DIVU gives {5, 0xFFFFFFFF} at T+33.
- Abort cases, each of which must also accept a fresh DIVU 9 / 3 → {0, 3} afterwards:
  - annul_in pulsed at iteration 10 → returns to DIV_FREE, ready never asserts.
  - start_in dropped at iteration 20 → same behaviour.
- rst asserted asynchronously mid-DIV_ON → ready_out and result_out are 0 immediately; the divider is idle after release.
